// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory/writeback stage.
//   XLEN           datapath width
//   F3_*           load/store funct3 width/sign codes
//   wb_state_e     stage controller state encoding
//   access_ok()    true when a load/store funct3 is defined and the address
//                  is naturally aligned for its width
package rv32i_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } wb_state_e;

   function automatic logic access_ok(input logic       is_load,
                                      input logic [2:0] funct3,
                                      input logic [1:0] byte_off);
      logic ok;
      ok = 1'b0;
      if (is_load) begin
         case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~byte_off[0];
            F3_LW:         ok = (byte_off == 2'b00);
            default:       ok = 1'b0;
         endcase
      end else begin
         case (funct3)
            F3_SB:   ok = 1'b1;
            F3_SH:   ok = ~byte_off[0];
            F3_SW:   ok = (byte_off == 2'b00);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/mem_writeback_stage_load_align.sv
// Load data alignment: selects the byte/halfword lane addressed by the low
// address bits and sign- or zero-extends it to a full register value.
//   rdata     in   32  raw word returned by memory
//   byte_off  in   2   low address bits of the load
//   funct3    in   3   load width/sign code
//   value     out  32  register-file value
module load_align
   import rv32i_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      byte_off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] value
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'h00;
      case (byte_off)
         2'd0:    lane_b = rdata[7:0];
         2'd1:    lane_b = rdata[15:8];
         2'd2:    lane_b = rdata[23:16];
         default: lane_b = rdata[31:24];
      endcase
      // Halfword loads are only issued with byte_off[0] clear
      lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      value = rdata;
      case (funct3)
         F3_LB:   value = {{24{lane_b[7]}}, lane_b};
         F3_LH:   value = {{16{lane_h[15]}}, lane_h};
         F3_LW:   value = rdata;
         F3_LBU:  value = {24'h000000, lane_b};
         F3_LHU:  value = {16'h0000, lane_h};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_writeback_stage.sv
// RV32I memory + writeback stage. Accepts one instruction from EX, performs
// its data-memory access over a req/ready + rvalid interface, aligns load
// data and drives the register-file write port for a single cycle.
//   clk, rst_n                clock, async active-low reset
//   ex_valid / ex_ready       EX handshake (ready only while idle)
//   ex_rd, ex_reg_write       destination register and write flag
//   ex_mem_read/_write        load / store select
//   ex_funct3                 load/store width code
//   ex_result                 ALU result or byte address
//   ex_store_data             store source
//   mem_req/ready/we/addr/wdata/wstrb   memory request channel
//   mem_rvalid/rdata          load response channel
//   rd, data_in, RegWrite     register-file write port
//   mem_err                   sticky misalignment / timeout flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for EX; ALU ops retire from here in one cycle
// REQ     | mem_req held until mem_ready
// WAIT    | load accepted by memory, waiting for mem_rvalid
// WB      | register-file write pulse for the load, then IDLE
module mem_writeback_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] ex_store_data,
   output logic            mem_req,
   input  logic            mem_ready,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] data_in,
   output logic            RegWrite,
   output logic            mem_err
);

   localparam logic [TO_W:0] TO_LIMIT = (TO_W+1)'(MEM_TIMEOUT);

   wb_state_e       state_q, state_d;
   logic            ex_ready_q, ex_ready_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]      mem_wstrb_q, mem_wstrb_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] data_in_q, data_in_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_err_q, mem_err_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      off_q, off_d;
   logic [4:0]      ld_rd_q, ld_rd_d;
   logic            ld_wr_q, ld_wr_d;

   logic [TO_W:0]   to_inc;
   logic            to_expire;
   logic [3:0]      st_strb;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] load_val;
   logic            is_mem;
   logic            is_load;

   load_align u_load_align (
      .rdata    (mem_rdata),
      .byte_off (off_q),
      .funct3   (f3_q),
      .value    (load_val)
   );

   assign to_inc    = {1'b0, to_cnt_q} + (TO_W+1)'(1);
   assign to_expire = (to_inc >= TO_LIMIT);
   assign is_mem    = ex_mem_read | ex_mem_write;
   assign is_load   = ex_mem_read;

   // Store lanes: the addressed byte/halfword is replicated across the word
   // so memory only needs the strobes to place it.
   always_comb begin
      st_strb  = 4'b1111;
      st_wdata = ex_store_data;
      case (ex_funct3)
         F3_SB: begin
            st_strb  = 4'b0001 << ex_result[1:0];
            st_wdata = {4{ex_store_data[7:0]}};
         end
         F3_SH: begin
            st_strb  = 4'b0011 << ex_result[1:0];
            st_wdata = {2{ex_store_data[15:0]}};
         end
         default: begin
            st_strb  = 4'b1111;
            st_wdata = ex_store_data;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      rd_d        = rd_q;
      data_in_d   = data_in_q;
      reg_write_d = 1'b0;
      mem_err_d   = mem_err_q;
      to_cnt_d    = to_cnt_q;
      f3_d        = f3_q;
      off_d       = off_q;
      ld_rd_d     = ld_rd_q;
      ld_wr_d     = ld_wr_q;

      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               if (is_mem) begin
                  if (access_ok(is_load, ex_funct3, ex_result[1:0])) begin
                     state_d    = ST_REQ;
                     mem_req_d  = 1'b1;
                     mem_we_d   = ~is_load;
                     mem_addr_d = {ex_result[XLEN-1:2], 2'b00};
                     to_cnt_d   = '0;
                     f3_d       = ex_funct3;
                     off_d      = ex_result[1:0];
                     ld_rd_d    = ex_rd;
                     ld_wr_d    = is_load & ex_reg_write & (ex_rd != 5'd0);
                     if (is_load) begin
                        mem_wstrb_d = 4'b0000;
                     end else begin
                        mem_wstrb_d = st_strb;
                        mem_wdata_d = st_wdata;
                     end
                  end else begin
                     mem_err_d = 1'b1;
                  end
               end else if (ex_reg_write && (ex_rd != 5'd0)) begin
                  reg_write_d = 1'b1;
                  rd_d        = ex_rd;
                  data_in_d   = ex_result;
               end
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               mem_req_d = 1'b0;
               to_cnt_d  = '0;
               state_d   = mem_we_q ? ST_IDLE : ST_WAIT;
            end else if (to_expire) begin
               mem_req_d = 1'b0;
               mem_err_d = 1'b1;
               to_cnt_d  = '0;
               state_d   = ST_IDLE;
            end else begin
               to_cnt_d = to_inc[TO_W-1:0];
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_d = ST_WB;
               if (ld_wr_q) begin
                  reg_write_d = 1'b1;
                  rd_d        = ld_rd_q;
                  data_in_d   = load_val;
               end
            end else if (to_expire) begin
               mem_err_d = 1'b1;
               to_cnt_d  = '0;
               state_d   = ST_IDLE;
            end else begin
               to_cnt_d = to_inc[TO_W-1:0];
            end
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      ex_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ex_ready_q  <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         rd_q        <= 5'd0;
         data_in_q   <= '0;
         reg_write_q <= 1'b0;
         mem_err_q   <= 1'b0;
         to_cnt_q    <= '0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         ld_rd_q     <= 5'd0;
         ld_wr_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ex_ready_q  <= ex_ready_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         rd_q        <= rd_d;
         data_in_q   <= data_in_d;
         reg_write_q <= reg_write_d;
         mem_err_q   <= mem_err_d;
         to_cnt_q    <= to_cnt_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         ld_rd_q     <= ld_rd_d;
         ld_wr_q     <= ld_wr_d;
      end
   end

   assign ex_ready  = ex_ready_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign rd        = rd_q;
   assign data_in   = data_in_q;
   assign RegWrite  = reg_write_q;
   assign mem_err   = mem_err_q;

endmodule
